// File: rtl/mbit_trie_lookup.sv
// Multibit-trie longest-prefix-match lookup: one trie level per pipeline stage.
// It has valid/ready flow control with a global stall and a per-level table write port.
module mbit_trie_lookup #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STRIDE     = 4,
  parameter int unsigned NH_W       = 8,
  parameter int unsigned PTR_W      = 10,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned DEFAULT_NH = 0,
  localparam int unsigned LEVELS    = ADDR_W / STRIDE,
  localparam int unsigned LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_key,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NH_W-1:0]           out_nexthop,
  output logic                      out_hit,
  output logic [TAG_W-1:0]          out_tag,
  input  logic                      wr_en,
  input  logic [LVL_W-1:0]          wr_level,
  input  logic [PTR_W+STRIDE-1:0]   wr_addr,
  input  logic [2+NH_W+PTR_W-1:0]   wr_data
);

  localparam int unsigned ENT_W = 2 + NH_W + PTR_W;
  localparam int unsigned IDX_W = PTR_W + STRIDE;
  localparam int unsigned DEPTH = 1 << IDX_W;

  if (ADDR_W % STRIDE != 0) begin : g_bad_stride
    $error("ADDR_W must be a multiple of STRIDE");
  end

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] key;
    logic [TAG_W-1:0]  tag;
    logic [PTR_W-1:0]  ptr;
    logic              active;
    logic [NH_W-1:0]   best_nh;
    logic              best_valid;
  } stage_t;

  stage_t [LEVELS-1:0] s_q, s_d;
  stage_t              src0;
  logic                stall;
  logic                accept;

  assign stall    = s_q[LEVELS-1].valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  always_comb begin
    src0        = '0;
    src0.valid  = accept;
    src0.key    = in_key;
    src0.tag    = in_tag;
    src0.active = 1'b1;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    logic [ENT_W-1:0]  tbl [DEPTH];
    stage_t            src;
    stage_t            nxt;
    logic [STRIDE-1:0] chunk;
    logic [IDX_W-1:0]  rd_idx;
    logic [ENT_W-1:0]  ent;

    if (k == 0) begin : g_first
      assign src = src0;
    end else begin : g_next
      assign src = s_q[k-1];
    end

    assign chunk  = src.key[ADDR_W-1-k*STRIDE -: STRIDE];
    assign rd_idx = {src.ptr, chunk};
    assign ent    = tbl[rd_idx];

    // Table is deliberately not reset and keeps writing through stalls.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_level == LVL_W'(k))) begin
        tbl[wr_addr] <= wr_data;
      end
    end

    always_comb begin
      nxt = src;
      if (src.active) begin
        if (ent[ENT_W-2]) begin
          nxt.best_nh    = ent[PTR_W +: NH_W];
          nxt.best_valid = 1'b1;
        end
        nxt.active = ent[ENT_W-1];
        nxt.ptr    = ent[PTR_W-1:0];
      end
    end

    assign s_d[k] = nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '0;
    end else if (!stall) begin
      s_q <= s_d;
    end
  end

  assign out_valid   = s_q[LEVELS-1].valid;
  assign out_hit     = s_q[LEVELS-1].best_valid;
  assign out_nexthop = s_q[LEVELS-1].best_valid ? s_q[LEVELS-1].best_nh : NH_W'(DEFAULT_NH);
  assign out_tag     = s_q[LEVELS-1].tag;

  logic unused_last;
  assign unused_last = ^{s_q[LEVELS-1].key, s_q[LEVELS-1].ptr, s_q[LEVELS-1].active};

endmodule
